// File: rtl/guess_entry_pkg.sv
// rtl/guess_entry_pkg.sv - shared constants and state encoding for the guess entry front-end
package guess_entry_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CNT_W      = 3;
  localparam int HOLD_W     = 4;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    FULL  = 2'd1,
    LOCK  = 2'd2
  } entry_state_t;

  function automatic logic code_legal(input logic [DIGIT_W-1:0] code, input int max_digit);
    return int'(code) <= max_digit;
  endfunction

endpackage

// File: rtl/guess_entry_if.sv
// rtl/guess_entry_if.sv - keypad inputs and game-core outputs of the guess entry block
interface guess_entry_if;

  logic [guess_entry_pkg::DIGIT_W-1:0] key_code;
  logic                                key_valid;
  logic                                key_back;
  logic                                key_enter;
  logic [guess_entry_pkg::DIGIT_W-1:0] ans0;
  logic [guess_entry_pkg::DIGIT_W-1:0] ans1;
  logic [guess_entry_pkg::DIGIT_W-1:0] ans2;
  logic [guess_entry_pkg::DIGIT_W-1:0] ans3;
  logic [guess_entry_pkg::CNT_W-1:0]   digit_cnt;
  logic                                enter;
  logic                                reject;
  logic                                locked;

  modport master (
    output key_code, key_valid, key_back, key_enter,
    input  ans0, ans1, ans2, ans3, digit_cnt, enter, reject, locked
  );

  modport slave (
    input  key_code, key_valid, key_back, key_enter,
    output ans0, ans1, ans2, ans3, digit_cnt, enter, reject, locked
  );

endinterface

// File: rtl/guess_entry_edge_pulse.sv
// rtl/guess_entry_edge_pulse.sv - rising-edge detector whose history resets high
module guess_entry_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Resetting history to 1 keeps a button held through reset from firing.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/guess_entry.sv
// rtl/guess_entry.sv - 4-digit keypad entry with backspace, gated commit and hold-off lockout
module guess_entry
  import guess_entry_pkg::*;
#(
  parameter int HOLDOFF   = 3,
  parameter int MAX_DIGIT = 9
) (
  input  logic          clka,
  input  logic          reset,
  guess_entry_if.slave  bus
);

  entry_state_t             state_q, state_n;
  logic [HOLD_W-1:0]        hold_q, hold_n;
  logic [CNT_W-1:0]         cnt_q, cnt_n;
  logic [DIGIT_W-1:0]       ans_q [NUM_DIGITS];
  logic [DIGIT_W-1:0]       ans_n [NUM_DIGITS];
  logic                     enter_q, enter_n;
  logic                     reject_q, reject_n;
  logic                     enter_rise;
  logic [1:0]               wr_idx;
  logic [1:0]               bk_idx;

  guess_entry_edge_pulse u_enter_edge (
    .clk   (clka),
    .reset (reset),
    .level (bus.key_enter),
    .rise  (enter_rise)
  );

  assign wr_idx = cnt_q[1:0];
  assign bk_idx = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q  <= ENTRY;
      hold_q   <= '0;
      cnt_q    <= '0;
      enter_q  <= 1'b0;
      reject_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        ans_q[i] <= '0;
      end
    end else begin
      state_q  <= state_n;
      hold_q   <= hold_n;
      cnt_q    <= cnt_n;
      enter_q  <= enter_n;
      reject_q <= reject_n;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        ans_q[i] <= ans_n[i];
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    hold_n   = hold_q;
    cnt_n    = cnt_q;
    enter_n  = 1'b0;
    reject_n = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ans_n[i] = ans_q[i];
    end

    case (state_q)
      LOCK: begin
        if (hold_q <= HOLD_W'(1)) begin
          state_n = ENTRY;
          hold_n  = '0;
        end else begin
          hold_n = hold_q - HOLD_W'(1);
        end
      end

      ENTRY, FULL: begin
        // One action per cycle: commit beats backspace beats new digit.
        if (enter_rise) begin
          if (state_q == FULL) begin
            enter_n = 1'b1;
            cnt_n   = '0;
            state_n = LOCK;
            hold_n  = HOLD_W'(HOLDOFF);
          end else begin
            reject_n = 1'b1;
          end
        end else if (bus.key_back) begin
          if (cnt_q != '0) begin
            ans_n[bk_idx] = '0;
            cnt_n         = cnt_q - CNT_W'(1);
            state_n       = ENTRY;
          end else begin
            reject_n = 1'b1;
          end
        end else if (bus.key_valid) begin
          if (!code_legal(bus.key_code, MAX_DIGIT) || state_q == FULL) begin
            reject_n = 1'b1;
          end else begin
            // First digit after a commit wipes the stale tail of the last entry.
            if (cnt_q == '0) begin
              for (int i = 1; i < NUM_DIGITS; i++) begin
                ans_n[i] = '0;
              end
            end
            ans_n[wr_idx] = bus.key_code;
            cnt_n         = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
              state_n = FULL;
            end
          end
        end
      end

      default: begin
        state_n = ENTRY;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.ans0      = ans_q[0];
  assign bus.ans1      = ans_q[1];
  assign bus.ans2      = ans_q[2];
  assign bus.ans3      = ans_q[3];
  assign bus.digit_cnt = cnt_q;
  assign bus.enter     = enter_q;
  assign bus.reject    = reject_q;
  assign bus.locked    = (state_q == LOCK);

endmodule

// File: tb/tb_guess_entry.sv
// tb/tb_guess_entry.sv - directed and randomized checks of guess_entry against a queue-based model
module tb_guess_entry;

  localparam int HOLDOFF   = 3;
  localparam int MAX_DIGIT = 9;

  logic clka = 1'b0;
  logic reset;

  guess_entry_if bus ();

  guess_entry #(
    .HOLDOFF   (HOLDOFF),
    .MAX_DIGIT (MAX_DIGIT)
  ) dut (
    .clka  (clka),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  // Model: the digits typed so far, the four displayed values, and the lockout time left.
  int digits[$];
  int shown[4];
  int lock_left;
  bit prev_e;
  bit exp_enter;
  bit exp_reject;

  int enter_seen;
  int locked_seen;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_update(input bit v, input int c, input bit b, input bit e, input bit r);
    bit rise;
    if (r) begin
      digits.delete();
      shown      = '{0, 0, 0, 0};
      lock_left  = 0;
      prev_e     = 1'b1;
      exp_enter  = 1'b0;
      exp_reject = 1'b0;
      return;
    end
    rise       = e && !prev_e;
    prev_e     = e;
    exp_enter  = 1'b0;
    exp_reject = 1'b0;
    if (lock_left > 0) begin
      lock_left--;
      return;
    end
    if (rise) begin
      if (digits.size() == 4) begin
        exp_enter = 1'b1;
        digits.delete();
        lock_left = HOLDOFF;
      end else begin
        exp_reject = 1'b1;
      end
    end else if (b) begin
      if (digits.size() > 0) begin
        void'(digits.pop_back());
        shown[digits.size()] = 0;
      end else begin
        exp_reject = 1'b1;
      end
    end else if (v) begin
      if (c > MAX_DIGIT || digits.size() == 4) begin
        exp_reject = 1'b1;
      end else begin
        if (digits.size() == 0) shown = '{c, 0, 0, 0};
        else shown[digits.size()] = c;
        digits.push_back(c);
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("ans0", int'(bus.ans0), shown[0]);
    check_eq("ans1", int'(bus.ans1), shown[1]);
    check_eq("ans2", int'(bus.ans2), shown[2]);
    check_eq("ans3", int'(bus.ans3), shown[3]);
    check_eq("digit_cnt", int'(bus.digit_cnt), digits.size());
    check_eq("enter", int'(bus.enter), int'(exp_enter));
    check_eq("reject", int'(bus.reject), int'(exp_reject));
    check_eq("locked", int'(bus.locked), int'(lock_left > 0));
    check_eq("enter_reject_excl", int'(bus.enter & bus.reject), 0);
    if (bus.enter) enter_seen++;
    if (bus.locked) locked_seen++;
  endtask

  task automatic step(input bit v, input int c, input bit b, input bit e, input bit r);
    bus.key_valid = v;
    bus.key_code  = 4'(c);
    bus.key_back  = b;
    bus.key_enter = e;
    reset         = r;
    model_update(v, c, b, e, r);
    @(negedge clka);
    compare_all();
  endtask

  task automatic type_digit(input int c);
    step(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit e);
    step(1'b0, 0, 1'b0, e, 1'b0);
  endtask

  initial begin
    bit ke;
    int c;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.key_back  = 1'b0;
    bus.key_enter = 1'b0;
    reset         = 1'b1;
    @(negedge clka);

    // Reset state
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_cnt", int'(bus.digit_cnt), 0);
    check_eq("reset_locked", int'(bus.locked), 0);

    // Basic entry and commit with enter held for five cycles
    type_digit(1); type_digit(2); type_digit(3); type_digit(4);
    check_eq("basic_ans0", int'(bus.ans0), 1);
    check_eq("basic_ans3", int'(bus.ans3), 4);
    check_eq("basic_cnt", int'(bus.digit_cnt), 4);
    enter_seen  = 0;
    locked_seen = 0;
    for (int i = 0; i < 5; i++) idle(1'b1);
    check_eq("basic_enter_pulses", enter_seen, 1);
    check_eq("basic_locked_cycles", locked_seen, HOLDOFF);
    check_eq("basic_cnt_after", int'(bus.digit_cnt), 0);
    check_eq("basic_ans2_held", int'(bus.ans2), 3);
    idle(1'b0);

    // Early enter with two digits
    type_digit(5); type_digit(6);
    idle(1'b1);
    check_eq("early_reject", int'(bus.reject), 1);
    check_eq("early_enter", int'(bus.enter), 0);
    check_eq("early_cnt", int'(bus.digit_cnt), 2);
    idle(1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Backspace and overflow
    type_digit(1); type_digit(2); type_digit(3); type_digit(4);
    type_digit(7);
    check_eq("ovf_reject", int'(bus.reject), 1);
    check_eq("ovf_ans3", int'(bus.ans3), 4);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("back_ans3", int'(bus.ans3), 0);
    check_eq("back_cnt", int'(bus.digit_cnt), 3);
    type_digit(8);
    check_eq("refill_ans3", int'(bus.ans3), 8);
    check_eq("refill_cnt", int'(bus.digit_cnt), 4);

    // Illegal code and same-cycle priority
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    type_digit(12);
    check_eq("illegal_reject", int'(bus.reject), 1);
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    check_eq("prio_cnt", int'(bus.digit_cnt), 1);
    check_eq("prio_reject", int'(bus.reject), 0);

    // Lockout and restart
    type_digit(2); type_digit(3); type_digit(4);
    idle(1'b1);
    check_eq("lock_enter", int'(bus.enter), 1);
    step(1'b1, 9, 1'b0, 1'b1, 1'b0);
    check_eq("lock_cnt", int'(bus.digit_cnt), 0);
    check_eq("lock_reject", int'(bus.reject), 0);
    idle(1'b1); idle(1'b1);
    check_eq("lock_released", int'(bus.locked), 0);
    idle(1'b0);
    type_digit(9);
    check_eq("restart_ans0", int'(bus.ans0), 9);
    check_eq("restart_ans1", int'(bus.ans1), 0);
    check_eq("restart_ans3", int'(bus.ans3), 0);

    // Reset in the cycle enter is high, button still held afterwards
    type_digit(1); type_digit(1); type_digit(1);
    idle(1'b1);
    check_eq("rst_pre_enter", int'(bus.enter), 1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_ans0", int'(bus.ans0), 0);
    check_eq("rst_enter", int'(bus.enter), 0);
    enter_seen = 0;
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_eq("rst_no_enter", enter_seen, 0);
    idle(1'b0);

    // Randomized traffic against the model
    ke = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 12) ke = ~ke;
      c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      step($urandom_range(0, 99) < 45, c, $urandom_range(0, 99) < 12, ke,
           $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
Name: guess_entry

Overview:
- Upstream front-end for the 1A2B datapath and main FSM.
- Collects a 4-digit guess or test answer one keypad digit at a time, with backspace support.
- Converts the raw, level-sensitive enter button into a single-cycle commit pulse, gated on a complete 4-digit entry.
- Drives the ans0..ans3 buses and the enter strobe that feed the game core, then locks out further input for a short hold-off window.

Parameters:
- HOLDOFF, 3, cycles after a commit during which all key inputs are ignored (range 1..15).
- MAX_DIGIT, 9, largest legal key_code; larger codes are rejected.

Ports:
- clka  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_code  input  4  digit value from the keypad, sampled only when key_valid=1.
- key_valid  input  1  one-cycle strobe: key_code holds a new digit.
- key_back  input  1  one-cycle strobe: delete the last entered digit.
- key_enter  input  1  raw enter button level; held high for any number of cycles.
- ans0  output  4  first-entered digit.
- ans1  output  4  second-entered digit.
- ans2  output  4  third-entered digit.
- ans3  output  4  fourth-entered digit.
- digit_cnt  output  3  number of digits currently entered, 0..4.
- enter  output  1  one-cycle commit pulse to the main FSM.
- reject  output  1  one-cycle pulse: last key action was refused.
- locked  output  1  high during the hold-off window.

Behaviour:
- Reset (synchronous): ans0..ans3=0, digit_cnt=0, enter=0, reject=0, locked=0, state=ENTRY, hold-off counter=0, enter_prev=1. Setting enter_prev=1 means a button held through reset does not commit.
- Edge detect: enter_rise = key_enter & ~enter_prev. enter_prev is registered every cycle, including while locked.
- States:
  - ENTRY: digit_cnt is 0..3.
  - FULL: digit_cnt=4.
  - LOCK: hold-off after a commit.
- Action priority within one cycle in ENTRY/FULL (highest wins; lower-priority actions that cycle are discarded without a reject):
  1. enter_rise
  2. key_back
  3. key_valid
- enter_rise in FULL:
  - enter=1 on the next cycle (1-cycle latency from the rising edge).
  - digit_cnt←0; ans0..ans3 held unchanged.
  - State→LOCK, with the hold-off counter loaded to HOLDOFF.
- enter_rise in ENTRY: reject=1 next cycle; no other change.
- key_back:
  - If digit_cnt>0: the digit at position digit_cnt-1 is set to 0, then digit_cnt decrements.
  - FULL→ENTRY on this action.
  - If digit_cnt=0: reject=1.
- key_valid:
  - If key_code>MAX_DIGIT or state is FULL: reject=1, no change.
  - Otherwise write key_code to ans[digit_cnt] and increment digit_cnt.
  - On reaching 4, state→FULL.
  - If this is the first digit after a commit (digit_cnt=0), ans1..ans3 are cleared to 0 in the same cycle.
- Duplicate digits are accepted here; duplicate detection belongs to the datapath.
- LOCK:
  - locked=1.
  - key_valid, key_back and enter_rise are ignored, with no reject.
  - The counter decrements each cycle; at 1 the state→ENTRY with locked=0 on the following cycle.
  - Total locked cycles = HOLDOFF.
- Stability: enter and reject are never high in the same cycle. Both are pulses of exactly one cycle. ans0..ans3 are stable for the cycle enter=1 and for the whole LOCK window.
- Reset mid-operation (any state, including LOCK or the cycle enter is high): all registers return to reset values next cycle, and no further enter pulse is produced.

Decomposition:
- Shared package (game_pkg):
  - state encoding constants ENTRY/FULL/LOCK (2-bit);
  - NUM_DIGITS=4;
  - DIGIT_W=4.
  - The datapath reuses NUM_DIGITS and DIGIT_W.
- One natural sub-module: edge_pulse (registered rising-edge detector with a reset value of 1). It is reusable for the restart and loadtest buttons.
- The remainder is a single always block for the FSM plus the digit register file.

Test Plan:
- Basic entry and commit: digits 1,2,3,4 on consecutive key_valid, then key_enter high for 5 cycles. Expect:
  - ans0..3=1,2,3,4 and digit_cnt=4;
  - a single enter pulse 1 cycle after the rise;
  - locked high for exactly 3 cycles;
  - digit_cnt=0.
- Early enter: digits 5,6 entered, then enter rise. Expect reject=1 for one cycle, enter stays 0, digit_cnt=2.
- Backspace and overflow: digits 1,2,3,4 entered.
  - Then key_valid 7: expect reject and ans unchanged.
  - Then key_back: expect ans3=0, digit_cnt=3.
  - Then digit 8: expect ans3=8, FULL.
- Illegal code and priority:
  - key_code=12 with key_valid: expect reject.
  - Same-cycle key_back+key_valid at digit_cnt=2: expect digit_cnt=1, digit ignored, no reject.
- Lockout and restart:
  - During LOCK, key_valid 9: expect no change, no reject.
  - After LOCK, digit 9: expect ans0=9, ans1..3=0.
- Reset mid-operation: assert reset in the cycle enter=1 with key_enter held high. Expect:
  - all outputs 0 next cycle;
  - no enter pulse after reset deasserts while key_enter stays high.
